audio_playback_scheduler: RTL and testbench

Sits downstream of the SPI-style audio receiver and decides when each received 16-bit word is played. Words arrive in bursts on the receiver's data_ready pulse; the block buffers them in a small FIFO, prefills, then releases exactly one sample per sample-rate tick. It drains the buffer cleanly when the link goes inactive and reports underrun/overrun status for debug.

---
 rtl/audio_pkg.sv | 15 +
 rtl/sample_tick_gen.sv | 27 ++
 rtl/audio_playback_scheduler.sv | 158 +++++++++++++++
 tb/tb_audio_playback_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio playback scheduler: sample width, counter
// saturation limit and the scheduler state encoding.
package audio_pkg;

    localparam int AUDIO_W = 16;
    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t PREFILL = 2'd1;
    localparam state_t PLAY    = 2'd2;
    localparam state_t DRAIN   = 2'd3;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: tick is high for one cycle every DIV
// cycles, on the cycle where the counter sits at DIV-1.
module sample_tick_gen #(
    parameter int DIV = 3125
) (
    input  logic clk_25mhz,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == CW'(DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_playback_scheduler.sv
// Buffers received audio words in a small FIFO, prefills, then releases one
// sample per sample-rate tick; drains on link loss and reports under/overrun.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | nothing buffered for playback, waiting for the first word
//   PREFILL | collecting words until PREFILL_LEVEL is reached
//   PLAY    | link active, one pop per tick, empty ticks count as underrun
//   DRAIN   | link gone, pop remaining words per tick, empty tick ends it
module audio_playback_scheduler
    import audio_pkg::*;
#(
    parameter int CLOCK_HZ      = 25_000_000,
    parameter int SAMPLE_RATE   = 8_000,
    parameter int FIFO_DEPTH    = 16,
    parameter int PREFILL_LEVEL = 8
) (
    input  logic                          clk_25mhz,
    input  logic                          reset_n,
    input  logic                          data_ready,
    input  logic [AUDIO_W-1:0]            audio_in,
    input  logic                          com_active,
    input  logic                          clear_status,
    output logic [AUDIO_W-1:0]            sample_out,
    output logic                          sample_valid,
    output logic                          playing,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    underrun_count,
    output logic                          overrun
);

    localparam int DIV = CLOCK_HZ / SAMPLE_RATE;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;

    logic tick;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_25mhz (clk_25mhz),
        .reset_n   (reset_n),
        .tick      (tick)
    );

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [AUDIO_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AUDIO_W-1:0]  sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                playing_q, playing_d;
    logic [7:0]          underrun_q, underrun_d;
    logic                overrun_q, overrun_d;

    logic active_st;
    logic empty;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;
    logic empty_tick;

    // All FIFO decisions use the level at the start of the cycle, so a word
    // pushed on a tick cannot be popped by that same tick.
    assign active_st  = (state_q == PLAY) || (state_q == DRAIN);
    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign pop        = tick && active_st && !empty;
    assign push_ok    = data_ready && (!full || pop);
    assign drop       = data_ready && full && !pop;
    assign empty_tick = tick && active_st && empty;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_ready) state_d = PREFILL;
            end
            PREFILL: begin
                if (level_q >= LW'(PREFILL_LEVEL)) state_d = PLAY;
                else if (!com_active)              state_d = empty ? IDLE : DRAIN;
            end
            PLAY: begin
                if (!com_active) state_d = DRAIN;
            end
            DRAIN: begin
                if (empty_tick)      state_d = IDLE;
                else if (com_active) state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_d = sample_q;
        if (pop)             sample_d = mem_q[rd_ptr_q];
        else if (empty_tick) sample_d = '0;

        valid_d   = pop;
        playing_d = (state_d == PLAY) || (state_d == DRAIN);

        underrun_d = underrun_q;
        if (clear_status) begin
            underrun_d = '0;
        end else if (empty_tick && (state_q == PLAY) && (underrun_q != UNDERRUN_MAX)) begin
            underrun_d = underrun_q + 8'd1;
        end

        overrun_d = overrun_q;
        if (clear_status) overrun_d = 1'b0;
        else if (drop)    overrun_d = 1'b1;
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
            underrun_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            playing_q  <= playing_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk_25mhz) begin
        if (push_ok) mem_q[wr_ptr_q] <= audio_in;
    end

    assign sample_out     = sample_q;
    assign sample_valid   = valid_q;
    assign playing        = playing_q;
    assign fifo_level     = level_q;
    assign underrun_count = underrun_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Directed bench for audio_playback_scheduler with DIV=10, 4-entry FIFO,
// prefill of 2; tick timing comes from an independent counter model.
module tb_audio_playback_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        data_ready = 1'b0;
    logic [15:0] audio_in = '0;
    logic        com_active = 1'b0;
    logic        clear_status = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        playing;
    logic [2:0]  fifo_level;
    logic [7:0]  underrun_count;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt;
    logic m_tick;

    audio_playback_scheduler #(
        .CLOCK_HZ      (100),
        .SAMPLE_RATE   (10),
        .FIFO_DEPTH    (4),
        .PREFILL_LEVEL (2)
    ) dut (
        .clk_25mhz      (clk),
        .reset_n        (rst_n),
        .data_ready     (data_ready),
        .audio_in       (audio_in),
        .com_active     (com_active),
        .clear_status   (clear_status),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .playing        (playing),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 0;
        else        m_cnt <= (m_cnt == 9) ? 0 : m_cnt + 1;
    end
    assign m_tick = (m_cnt == 9);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to_tick();
        int n = 0;
        while (!m_tick && n < 20) begin
            step();
            n++;
        end
        if (!m_tick) check("tick_wait", 32'(m_tick), 32'd1);
    endtask

    task automatic push(input logic [15:0] w);
        data_ready = 1'b1;
        audio_in   = w;
        step();
        data_ready = 1'b0;
    endtask

    task automatic tick_and_step();
        go_to_tick();
        step();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_sample", 32'(sample_out), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_playing", 32'(playing), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_underrun", 32'(underrun_count), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Test 1: asynchronous reset mid-stream
        com_active = 1'b1;
        push(16'hAAA1);
        push(16'hAAA2);
        push(16'hAAA3);
        begin
            int r = int'($urandom_range(0, 3));
            for (int i = 0; i < r; i++) step();
        end
        #3 rst_n = 1'b0;
        #1;
        check("t1_level", 32'(fifo_level), 32'h0);
        check("t1_playing", 32'(playing), 32'h0);
        check("t1_sample", 32'(sample_out), 32'h0);
        check("t1_valid", 32'(sample_valid), 32'h0);
        step();
        rst_n = 1'b1;

        // Test 2: prefill and start
        push(16'h1111);
        push(16'h2222);
        step();
        check("t2_playing", 32'(playing), 32'h1);
        check("t2_level", 32'(fifo_level), 32'd2);
        tick_and_step();
        check("t2_s1", 32'(sample_out), 32'h1111);
        check("t2_v1", 32'(sample_valid), 32'h1);
        check("t2_lvl1", 32'(fifo_level), 32'd1);
        step();
        check("t2_v1_pulse", 32'(sample_valid), 32'h0);
        tick_and_step();
        check("t2_s2", 32'(sample_out), 32'h2222);
        check("t2_v2", 32'(sample_valid), 32'h1);

        // Test 3: underrun
        tick_and_step();
        check("t3_sample", 32'(sample_out), 32'h0);
        check("t3_valid", 32'(sample_valid), 32'h0);
        check("t3_under1", 32'(underrun_count), 32'd1);
        tick_and_step();
        tick_and_step();
        check("t3_under3", 32'(underrun_count), 32'd3);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("t3_clear", 32'(underrun_count), 32'd0);

        // Test 6: push on an empty tick is not consumed by that tick
        go_to_tick();
        push(16'hABCD);
        check("t6_under", 32'(underrun_count), 32'd1);
        check("t6_level", 32'(fifo_level), 32'd1);
        check("t6_valid", 32'(sample_valid), 32'h0);
        check("t6_sample", 32'(sample_out), 32'h0);
        tick_and_step();
        check("t6_pop", 32'(sample_out), 32'hABCD);
        check("t6_pop_valid", 32'(sample_valid), 32'h1);
        check("t6_pop_level", 32'(fifo_level), 32'd0);

        // Test 4: overrun between ticks, then push+pop on a full FIFO
        push(16'hA001);
        push(16'hA002);
        push(16'hA003);
        push(16'hA004);
        push(16'hA005);
        check("t4_level", 32'(fifo_level), 32'd4);
        check("t4_overrun", 32'(overrun), 32'h1);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("t4_ovr_clear", 32'(overrun), 32'h0);
        go_to_tick();
        push(16'hA006);
        check("t4_full_lvl", 32'(fifo_level), 32'd4);
        check("t4_full_ovr", 32'(overrun), 32'h0);
        check("t4_full_pop", 32'(sample_out), 32'hA001);
        tick_and_step();
        check("t4_pop2", 32'(sample_out), 32'hA002);
        check("t4_lvl3", 32'(fifo_level), 32'd3);

        // Test 5: drain after link loss
        com_active = 1'b0;
        step();
        check("t5_playing", 32'(playing), 32'h1);
        tick_and_step();
        check("t5_d1", 32'(sample_out), 32'hA003);
        check("t5_v1", 32'(sample_valid), 32'h1);
        tick_and_step();
        check("t5_d2", 32'(sample_out), 32'hA004);
        check("t5_v2", 32'(sample_valid), 32'h1);
        tick_and_step();
        check("t5_d3", 32'(sample_out), 32'hA006);
        check("t5_v3", 32'(sample_valid), 32'h1);
        tick_and_step();
        check("t5_end_sample", 32'(sample_out), 32'h0);
        check("t5_end_valid", 32'(sample_valid), 32'h0);
        check("t5_end_playing", 32'(playing), 32'h0);
        check("t5_end_under", 32'(underrun_count), 32'd0);
        check("t5_end_level", 32'(fifo_level), 32'd0);

        // Underrun saturation and clear priority
        com_active = 1'b1;
        push(16'hB001);
        push(16'hB002);
        step();
        for (int i = 0; i < 260; i++) tick_and_step();
        check("sat_under", 32'(underrun_count), 32'd255);
        go_to_tick();
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("clr_priority", 32'(underrun_count), 32'd0);
        tick_and_step();
        check("after_clr", 32'(underrun_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
